src_bank_buf: RTL

Parametrised N-bank ping-pong source buffer sitting between the host DMA write port and the compute core's operand read port. The host fills one bank with wide words while the core reads narrow words from a previously filled bank. Per-bank full/empty ownership tracking gives the host a ready signal and the core a data-available signal. Protocol violations (write into an owned bank, read from an empty bank) are dropped and flagged with sticky error bits.

---
 rtl/src_bank_buf_if.sv | 35 +++
 rtl/src_bank_buf.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/src_bank_buf_if.sv
// Host-write / core-read bus of the banked source buffer.
// Host side:  src_v, src_a, src_d, src_last  ->  src_ready
// Core side:  exec, ia, exec_done            ->  exec_ready, d, d_v
// modport master : the host DMA and the compute core (they drive the strobes)
// modport slave  : the buffer itself
interface src_bank_buf_if #(
    parameter int DW_HOST = 64,
    parameter int DW_EXEC = 32,
    parameter int DEPTH   = 512
);
    localparam int AW = $clog2(DEPTH);
    localparam int LB = $clog2(DW_HOST / DW_EXEC);

    logic               src_v;
    logic [AW-1:0]      src_a;
    logic [DW_HOST-1:0] src_d;
    logic               src_last;
    logic               src_ready;
    logic               exec;
    logic [AW+LB-1:0]   ia;
    logic               exec_done;
    logic               exec_ready;
    logic [DW_EXEC-1:0] d;
    logic               d_v;

    modport master (
        output src_v, src_a, src_d, src_last, exec, ia, exec_done,
        input  src_ready, exec_ready, d, d_v
    );

    modport slave (
        input  src_v, src_a, src_d, src_last, exec, ia, exec_done,
        output src_ready, exec_ready, d, d_v
    );
endinterface

// File: rtl/src_bank_buf.sv
// N-bank ping-pong source buffer. The host fills one bank with wide words
// while the core reads narrow lanes from a previously filled bank. Each bank
// carries one EMPTY/FULL bit; the write pointer only advances on src_last and
// the read pointer only on exec_done. Protocol violations are dropped and
// recorded in sticky flags.
// Ports:
//   clk       clock, all state on the rising edge
//   reset     asynchronous active-high reset (memory contents are kept)
//   bus       host/core bus (slave side), see src_bank_buf_if
//   full_cnt  number of FULL banks, 0..NBANK
//   ovf       sticky: a host write hit a non-EMPTY bank and was dropped
//   udf       sticky: a read or release hit a non-FULL bank and was dropped
module src_bank_buf #(
    parameter int DW_HOST = 64,
    parameter int DW_EXEC = 32,
    parameter int DEPTH   = 512,
    parameter int NBANK   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    src_bank_buf_if.slave            bus,
    output logic [$clog2(NBANK):0]   full_cnt,
    output logic                     ovf,
    output logic                     udf
);
    localparam int R   = DW_HOST / DW_EXEC;
    localparam int AW  = $clog2(DEPTH);
    localparam int LB  = $clog2(R);
    localparam int BW  = $clog2(NBANK);
    localparam int LBW = (LB > 0) ? LB : 1;

    localparam logic [BW-1:0] PTR_ONE = 1;
    localparam logic [BW:0]   CNT_ONE = 1;

    logic [NBANK-1:0] full_reg, full_next;
    logic [BW-1:0]    wp_reg, rp_reg;
    logic [BW:0]      cnt_reg, cnt_next;
    logic             ovf_reg, udf_reg, d_v_reg;
    logic             has_data_reg;     // d reads 0 until the first accepted read
    logic [BW-1:0]    rd_bank_reg;      // bank whose read register feeds d
    logic [LBW-1:0]   lane_reg;

    logic             wr_acc, last_acc, rd_acc, done_acc;
    logic [AW-1:0]    word_addr;
    logic [LBW-1:0]   lane_in;
    logic [DW_HOST-1:0] bank_q [NBANK];
    logic [DW_HOST-1:0] rd_word;
    logic [DW_EXEC-1:0] lane_word [R];

    assign bus.src_ready  = ~full_reg[wp_reg];
    assign bus.exec_ready = full_reg[rp_reg];

    assign wr_acc   = bus.src_v & bus.src_ready;
    assign last_acc = wr_acc & bus.src_last;
    assign rd_acc   = bus.exec & bus.exec_ready;
    assign done_acc = bus.exec_done & bus.exec_ready;

    assign word_addr = bus.ia[AW+LB-1:LB];

    generate
        if (LB > 0) begin : g_lane
            assign lane_in = bus.ia[LB-1:0];
        end else begin : g_nolane
            assign lane_in = '0;
        end
    endgenerate

    // src_last and exec_done never address the same bank (one needs EMPTY,
    // the other FULL), so both updates can be applied independently.
    always_comb begin
        full_next = full_reg;
        if (last_acc) full_next[wp_reg] = 1'b1;
        if (done_acc) full_next[rp_reg] = 1'b0;
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (last_acc && !done_acc)      cnt_next = cnt_reg + CNT_ONE;
        else if (!last_acc && done_acc) cnt_next = cnt_reg - CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_reg     <= '0;
            wp_reg       <= '0;
            rp_reg       <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            udf_reg      <= 1'b0;
            d_v_reg      <= 1'b0;
            has_data_reg <= 1'b0;
            rd_bank_reg  <= '0;
            lane_reg     <= '0;
        end else begin
            full_reg <= full_next;
            cnt_reg  <= cnt_next;
            d_v_reg  <= rd_acc;
            if (last_acc) wp_reg <= wp_reg + PTR_ONE;
            if (done_acc) rp_reg <= rp_reg + PTR_ONE;
            if (bus.src_v && !bus.src_ready) ovf_reg <= 1'b1;
            if ((bus.exec || bus.exec_done) && !bus.exec_ready) udf_reg <= 1'b1;
            // The read completes from the pre-release rp even when exec_done
            // is asserted in the same cycle.
            if (rd_acc) begin
                rd_bank_reg  <= rp_reg;
                lane_reg     <= lane_in;
                has_data_reg <= 1'b1;
            end
        end
    end

    // One simple-dual-port RAM per bank. The read register only loads on a
    // read of its own bank, so it holds the last word until the next read.
    generate
        for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
            logic [DW_HOST-1:0] mem [DEPTH];
            logic [DW_HOST-1:0] rd_q_reg;

            always_ff @(posedge clk) begin
                if (wr_acc && wp_reg == BW'(gi))
                    mem[bus.src_a] <= bus.src_d;
                if (rd_acc && rp_reg == BW'(gi))
                    rd_q_reg <= mem[word_addr];
            end

            assign bank_q[gi] = rd_q_reg;
        end
    endgenerate

    assign rd_word = bank_q[rd_bank_reg];

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_lanes
            assign lane_word[gi] = rd_word[gi*DW_EXEC +: DW_EXEC];
        end
    endgenerate

    assign bus.d   = has_data_reg ? lane_word[lane_reg] : '0;
    assign bus.d_v = d_v_reg;
    assign full_cnt = cnt_reg;
    assign ovf      = ovf_reg;
    assign udf      = udf_reg;
endmodule
